// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues I-memory reads and presents one instruction per accepted cycle.
// Holds a stalled response locally and discards responses for reads that a redirect has made stale.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic        fetch_nop,
  output logic [31:0] pc_out_if,
  output logic [31:0] pc_plus4_if,
  output logic [31:0] inst_rdata_if,
  output logic        is_branch_if,
  output logic        is_jump_if
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [31:0] hold_q;
  logic [31:0] redir_tgt;
  logic [31:0] inst;
  logic        vld;
  logic [6:0]  opcode;
  logic        unused_lsbs;

  assign redir_tgt   = {redirect_pc[31:2], 2'b00};
  assign unused_lsbs = ^redirect_pc[1:0];

  always_comb begin
    vld  = 1'b0;
    inst = 32'h0000_0013;
    case (state)
      FETCH: begin
        if (imem_resp && !redirect && !pipe_stall) begin
          vld  = 1'b1;
          inst = imem_rdata;
        end
      end
      HOLD: begin
        if (!redirect) begin
          vld  = 1'b1;
          inst = hold_q;
        end
      end
      default: ;
    endcase
    if (rst) begin
      vld  = 1'b0;
      inst = 32'h0000_0013;
    end
  end

  assign opcode        = inst[6:0];
  assign if_valid      = vld;
  assign fetch_nop     = ~vld;
  assign inst_rdata_if = inst;
  assign is_branch_if  = vld & (opcode == 7'b1100011);
  assign is_jump_if    = vld & ((opcode == 7'b1101111) | (opcode == 7'b1100111));
  assign pc_out_if     = pc_q;
  assign pc_plus4_if   = pc_q + 32'd4;
  assign imem_read     = ~rst & (state != HOLD);
  assign imem_address  = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc_q   <= RESET_PC;
      tgt_q  <= 32'h0;
      hold_q <= 32'h0000_0013;
    end else begin
      case (state)
        FETCH: begin
          if (imem_resp) begin
            if (redirect) begin
              pc_q <= redir_tgt;
            end else if (pipe_stall) begin
              hold_q <= imem_rdata;
              state  <= HOLD;
            end else begin
              pc_q <= pc_q + 32'd4;
            end
          end else if (redirect) begin
            tgt_q <= redir_tgt;
            state <= DROP;
          end
        end
        HOLD: begin
          // Redirect beats stall: the held instruction is on the wrong path.
          if (redirect) begin
            pc_q  <= redir_tgt;
            state <= FETCH;
          end else if (!pipe_stall) begin
            pc_q  <= pc_q + 32'd4;
            state <= FETCH;
          end
        end
        DROP: begin
          // Read in flight cannot be cancelled; keep the address until it returns.
          if (redirect) tgt_q <= redir_tgt;
          if (imem_resp) begin
            pc_q  <= redirect ? redir_tgt : tgt_q;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        fetch_nop;
  logic [31:0] pc_out_if;
  logic [31:0] pc_plus4_if;
  logic [31:0] inst_rdata_if;
  logic        is_branch_if;
  logic        is_jump_if;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .pipe_stall(pipe_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .fetch_nop(fetch_nop), .pc_out_if(pc_out_if), .pc_plus4_if(pc_plus4_if),
    .inst_rdata_if(inst_rdata_if), .is_branch_if(is_branch_if), .is_jump_if(is_jump_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic rs, input logic [31:0] rdat);
    @(negedge clk);
    pipe_stall  = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_resp   = rs;
    imem_rdata  = rdat;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pipe_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_resp = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    pipe_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_resp = 1'b0; imem_rdata = 32'h0;
    #1;
    // T1 reset
    check("rst_read",  imem_read, 0);
    check("rst_nop",   fetch_nop, 1);
    check("rst_valid", if_valid, 0);
    check("rst_pc",    pc_out_if, 32'h4000_0060);
    check("rst_pc4",   pc_plus4_if, 32'h4000_0064);
    check("rst_inst",  inst_rdata_if, 32'h0000_0013);
    check("rst_jump",  is_jump_if, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_read", imem_read, 1);
    check("rel_addr", imem_address, 32'h4000_0060);

    // T2 streaming
    cyc(0, 0, 0, 1, 32'h0000_0013);
    check("t2_v0",   if_valid, 1);
    check("t2_pc0",  pc_out_if, 32'h4000_0060);
    check("t2_i0",   inst_rdata_if, 32'h0000_0013);
    check("t2_p40",  pc_plus4_if, 32'h4000_0064);
    cyc(0, 0, 0, 1, 32'h0010_0093);
    check("t2_v1",   if_valid, 1);
    check("t2_pc1",  pc_out_if, 32'h4000_0064);
    check("t2_i1",   inst_rdata_if, 32'h0010_0093);
    check("t2_br1",  is_branch_if, 0);
    cyc(0, 0, 0, 0, 32'h0);
    check("t2_addr", imem_address, 32'h4000_0068);
    check("t2_idle", fetch_nop, 1);

    // T3 stall on response
    do_reset();
    cyc(1, 0, 0, 1, 32'h0000_006F);
    check("t3_v_resp", if_valid, 0);
    check("t3_j_resp", is_jump_if, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0, 32'h0);
      check("t3_rd_hold", imem_read, 0);
      check("t3_v_hold",  if_valid, 1);
      check("t3_pc_hold", pc_out_if, 32'h4000_0060);
      check("t3_i_hold",  inst_rdata_if, 32'h0000_006F);
      check("t3_j_hold",  is_jump_if, 1);
    end
    cyc(0, 0, 0, 0, 32'h0);
    check("t3_v_acc", if_valid, 1);
    cyc(0, 0, 0, 0, 32'h0);
    check("t3_rd_next", imem_read, 1);
    check("t3_addr",    imem_address, 32'h4000_0064);
    check("t3_v_next",  if_valid, 0);

    // T4 redirect while read outstanding
    do_reset();
    cyc(0, 1, 32'h4000_0200, 0, 32'h0);
    check("t4_v0", if_valid, 0);
    check("t4_a0", imem_address, 32'h4000_0060);
    cyc(0, 0, 0, 0, 32'h0);
    check("t4_v1", if_valid, 0);
    check("t4_a1", imem_address, 32'h4000_0060);
    check("t4_r1", imem_read, 1);
    cyc(0, 0, 0, 1, 32'hDEAD_BEEF);
    check("t4_v2", if_valid, 0);
    check("t4_a2", imem_address, 32'h4000_0060);
    cyc(0, 0, 0, 0, 32'h0);
    check("t4_a3", imem_address, 32'h4000_0200);
    check("t4_r3", imem_read, 1);

    // T5 redirect coinciding with response, unaligned target
    do_reset();
    cyc(0, 1, 32'h4000_0203, 1, 32'h0000_0013);
    check("t5_v",   if_valid, 0);
    check("t5_nop", fetch_nop, 1);
    cyc(0, 0, 0, 0, 32'h0);
    check("t5_addr", imem_address, 32'h4000_0200);

    // PC+4 wrap at top of address space
    cyc(0, 1, 32'hFFFF_FFFE, 1, 32'h0);
    cyc(0, 0, 0, 1, 32'h0000_0067);
    check("wrap_v",  if_valid, 1);
    check("wrap_pc", pc_out_if, 32'hFFFF_FFFC);
    check("wrap_p4", pc_plus4_if, 32'h0000_0000);
    check("wrap_j",  is_jump_if, 1);

    // T6 redirect while holding a stalled branch
    do_reset();
    cyc(1, 0, 0, 1, 32'h0000_0063);
    cyc(1, 0, 0, 0, 32'h0);
    check("t6_v_hold", if_valid, 1);
    check("t6_b_hold", is_branch_if, 1);
    cyc(1, 1, 32'h4000_0100, 0, 32'h0);
    check("t6_v_red", if_valid, 0);
    check("t6_b_red", is_branch_if, 0);
    check("t6_i_red", inst_rdata_if, 32'h0000_0013);
    cyc(1, 0, 0, 0, 32'h0);
    check("t6_rd",   imem_read, 1);
    check("t6_addr", imem_address, 32'h4000_0100);

    // Newest redirect wins while a read is outstanding
    do_reset();
    cyc(0, 1, 32'h4000_0100, 0, 32'h0);
    cyc(0, 1, 32'h4000_0300, 0, 32'h0);
    check("t7_a", imem_address, 32'h4000_0060);
    cyc(0, 0, 0, 1, 32'h1234_5678);
    check("t7_v", if_valid, 0);
    cyc(0, 0, 0, 0, 32'h0);
    check("t7_addr", imem_address, 32'h4000_0300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
